cdb_writeback: RTL and testbench

//  Write-back stage of the Tomasulo pipeline, directly upstream of commit. Functional units
//  (FUs) hand finished results (ROB tag, value) to a one-entry holding buffer per FU. Each

---
 rtl/cdb_writeback.sv | 132 +++++++++++++
 tb/tb_cdb_writeback.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cdb_writeback.sv
// Write-back stage: one holding buffer per functional unit, round-robin arbitration
// onto a registered common data bus, plus a saturating stall counter.
module cdb_writeback #(
    parameter int NUM_FU = 3,
    parameter int ROB_W  = 2,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    output logic [NUM_FU-1:0]          fu_ready,
    input  logic [NUM_FU*ROB_W-1:0]    fu_tag,
    input  logic [NUM_FU*DATA_W-1:0]   fu_value,
    output logic                       cdb_valid,
    output logic [ROB_W-1:0]           cdb_tag,
    output logic [DATA_W-1:0]          cdb_value,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int PTR_W = $clog2(NUM_FU);
    localparam int POP_W = $clog2(NUM_FU + 1);

    // FU handshake: a result transfers at a posedge where fu_valid[i] & fu_ready[i];
    // fu_ready[i] never depends on fu_valid, only on buffer occupancy and the grant.
    logic [NUM_FU-1:0]             buf_full_q, buf_full_d;
    logic [NUM_FU-1:0][ROB_W-1:0]  buf_tag_q, buf_tag_d;
    logic [NUM_FU-1:0][DATA_W-1:0] buf_val_q, buf_val_d;
    logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                          cdb_valid_q, cdb_valid_d;
    logic [ROB_W-1:0]              cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]             cdb_value_q, cdb_value_d;
    logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;

    logic [NUM_FU-1:0] grant;
    logic              any_grant;
    logic [PTR_W-1:0]  win;
    logic [PTR_W-1:0]  cand;
    logic [POP_W-1:0]  pop;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_FU) s = s - NUM_FU;
        return PTR_W'(s);
    endfunction

    // Arbiter looks only at registered occupancy, so nothing from the FU ports reaches the CDB.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        win       = '0;
        cand      = '0;
        pop       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = wrap_add(rr_ptr_q, k);
            if (!any_grant && buf_full_q[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                win         = cand;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            pop = pop + POP_W'(buf_full_q[i]);
        end
    end

    assign fu_ready = ~buf_full_q | grant;

    always_comb begin
        buf_full_d  = buf_full_q;
        buf_tag_d   = buf_tag_q;
        buf_val_d   = buf_val_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            buf_full_d = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    buf_full_d[i] = 1'b1;
                    buf_tag_d[i]  = fu_tag[i*ROB_W +: ROB_W];
                    buf_val_d[i]  = fu_value[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    buf_full_d[i] = 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr_d    = (win == PTR_W'(NUM_FU - 1)) ? '0 : win + PTR_W'(1);
                cdb_valid_d = 1'b1;
                cdb_tag_d   = buf_tag_q[win];
                cdb_value_d = buf_val_q[win];
            end
            // A full buffer was left waiting this cycle; saturate rather than wrap.
            if ((pop > POP_W'(any_grant)) && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full_q  <= '0;
            buf_tag_q   <= '0;
            buf_val_q   <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            buf_full_q  <= buf_full_d;
            buf_tag_q   <= buf_tag_d;
            buf_val_q   <= buf_val_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cdb_writeback.sv
// Directed bench for cdb_writeback: a vector table for per-cycle behaviour plus
// hand sequences for reset-over-flush; a 2-bit-counter instance exercises saturation.
module tb_cdb_writeback;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [2:0]  fu_valid;
    logic [2:0]  fu_ready;
    logic [5:0]  fu_tag;
    logic [47:0] fu_value;
    logic        cdb_valid;
    logic [1:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic [15:0] stall_cnt;

    logic [2:0]  sat_ready;
    logic        sat_valid;
    logic [1:0]  sat_tag;
    logic [15:0] sat_value;
    logic [1:0]  sat_stall;

    int checks = 0;
    int errors = 0;

    cdb_writeback #(.NUM_FU(3), .ROB_W(2), .DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_tag(fu_tag), .fu_value(fu_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .stall_cnt(stall_cnt)
    );

    cdb_writeback #(.NUM_FU(3), .ROB_W(2), .DATA_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(sat_ready), .fu_tag(fu_tag), .fu_value(fu_value),
        .cdb_valid(sat_valid), .cdb_tag(sat_tag), .cdb_value(sat_value), .stall_cnt(sat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic        fl;
        logic [5:0]  tags;
        logic [47:0] vals;
        logic [2:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_tag;
        logic [15:0] exp_value;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] v, input logic fl,
                                input logic [1:0] t2, input logic [1:0] t1, input logic [1:0] t0,
                                input logic [15:0] v2, input logic [15:0] v1, input logic [15:0] v0,
                                input logic [2:0] rdy, input logic cv, input logic [1:0] ct,
                                input logic [15:0] cval, input logic [15:0] st);
        vec_t r;
        r.valid = v; r.fl = fl; r.tags = {t2, t1, t0}; r.vals = {v2, v1, v0};
        r.exp_ready = rdy; r.exp_valid = cv; r.exp_tag = ct; r.exp_value = cval; r.exp_stall = st;
        return r;
    endfunction

    function automatic logic [1:0] sat2(input logic [15:0] v);
        return (v > 16'd3) ? 2'd3 : v[1:0];
    endfunction

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tagname, input logic cv, input logic [1:0] ct,
                                 input logic [15:0] cval, input logic [15:0] st);
        check({tagname, " cdb_valid"}, 48'(cdb_valid), 48'(cv));
        check({tagname, " cdb_tag"}, 48'(cdb_tag), 48'(ct));
        check({tagname, " cdb_value"}, 48'(cdb_value), 48'(cval));
        check({tagname, " stall_cnt"}, 48'(stall_cnt), 48'(st));
        check({tagname, " sat_stall"}, 48'(sat_stall), 48'(sat2(st)));
    endtask

    initial begin
        // single FU1 result
        vecs.push_back(mk(3'b010, 0, 0, 2, 0, 0, 16'h00A5, 0, 3'b111, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 2, 16'h00A5, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 2, 16'h00A5, 0));
        // FU2 result brings the pointer back to 0
        vecs.push_back(mk(3'b100, 0, 1, 0, 0, 16'h1111, 0, 0, 3'b111, 0, 2, 16'h00A5, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 1, 16'h1111, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 1, 16'h1111, 0));
        // all three FUs at once, drained in RR order
        vecs.push_back(mk(3'b111, 0, 3, 1, 0, 16'h3003, 16'h2001, 16'h1000, 3'b111, 0, 1, 16'h1111, 0));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 16'h1000, 1));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b011, 1, 1, 16'h2001, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 3, 16'h3003, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3, 16'h3003, 2));
        // FU0 streaming back-to-back
        vecs.push_back(mk(3'b001, 0, 0, 0, 0, 0, 0, 16'h00A0, 3'b111, 0, 3, 16'h3003, 2));
        vecs.push_back(mk(3'b001, 0, 0, 0, 1, 0, 0, 16'h00A1, 3'b111, 1, 0, 16'h00A0, 2));
        vecs.push_back(mk(3'b001, 0, 0, 0, 2, 0, 0, 16'h00A2, 3'b111, 1, 1, 16'h00A1, 2));
        vecs.push_back(mk(3'b001, 0, 0, 0, 3, 0, 0, 16'h00A3, 3'b111, 1, 2, 16'h00A2, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 3, 16'h00A3, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3, 16'h00A3, 2));
        // fill 0 and 2, flush with a discarded FU1 handshake
        vecs.push_back(mk(3'b101, 0, 2, 0, 1, 16'h5552, 0, 16'h5550, 3'b111, 0, 3, 16'h00A3, 2));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 0, 16'h7777, 0, 3'b110, 0, 3, 16'h00A3, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3, 16'h00A3, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 3, 16'h00A3, 2));
        // sustained contention, ready gating and saturation of the narrow counter
        vecs.push_back(mk(3'b111, 0, 3, 2, 1, 16'h0B02, 16'h0B01, 16'h0B00, 3'b111, 0, 3, 16'h00A3, 2));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 16'h00C2, 16'h00C1, 16'h00C0, 3'b010, 1, 2, 16'h0B01, 3));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 3, 16'h0B02, 4));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b101, 1, 1, 16'h0B00, 5));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 1, 0, 16'h00C1, 5));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b111, 0, 0, 16'h00C1, 5));

        rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset fu_ready", 48'(fu_ready), 48'(3'b111));
        check_outputs("reset", 0, 0, 16'h0000, 0);

        for (int r = 0; r < vecs.size(); r++) begin
            fu_valid = vecs[r].valid;
            flush    = vecs[r].fl;
            fu_tag   = vecs[r].tags;
            fu_value = vecs[r].vals;
            #1;
            check($sformatf("row%0d fu_ready", r), 48'(fu_ready), 48'(vecs[r].exp_ready));
            step();
            check_outputs($sformatf("row%0d", r), vecs[r].exp_valid, vecs[r].exp_tag,
                          vecs[r].exp_value, vecs[r].exp_stall);
        end

        // reset wins over flush and over a pending buffered result
        fu_valid = 3'b001; flush = 1'b0; fu_tag = 6'b000010; fu_value = {32'h0, 16'hBEEF};
        step();
        rst = 1'b1; flush = 1'b1; fu_valid = 3'b111;
        step();
        rst = 1'b0; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
        #1;
        check("rst_flush fu_ready", 48'(fu_ready), 48'(3'b111));
        check_outputs("rst_flush", 0, 0, 16'h0000, 0);
        step();
        check_outputs("rst_idle", 0, 0, 16'h0000, 0);

        // pointer restarts at 0: FU1 must beat FU2
        fu_valid = 3'b110; fu_tag = {2'd3, 2'd1, 2'd0}; fu_value = {16'h0222, 16'h0111, 16'h0000};
        step();
        fu_valid = '0; fu_tag = '0; fu_value = '0;
        step();
        check_outputs("rr_restart first", 1, 1, 16'h0111, 1);
        step();
        check_outputs("rr_restart second", 1, 3, 16'h0222, 1);
        step();
        check_outputs("rr_restart idle", 0, 3, 16'h0222, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
